// File: rtl/ternary_pkg.sv
// ternary_pkg: shared trit, sequencer-state and CPU control-state encodings.
// Words are 9 balanced trits, 2 bits each; trit 0 occupies bits [1:0].
package ternary_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b10;
    localparam trit_t TRIT_BAD  = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOADING   = 2'd1,
        ST_EXECUTING = 2'd2,
        ST_HALTED    = 2'd3
    } sys_state_e;
    localparam logic [2:0] CPU_FETCH = 3'd0;
endpackage

// File: rtl/halt_detector.sv
// halt_detector: flags a CPU spinning on one PC for HALT_CYCLES consecutive fetches.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i restarts detection;
// en_i marks an executing cycle; cpu_pc_i/cpu_state_i observed CPU;
// halt_o high in the executing cycle whose fetch completes the stuck run.
module halt_detector
    import ternary_pkg::*;
#(
    parameter int WORD_W      = 18,
    parameter int HALT_CYCLES = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] cpu_pc_i,
    input  logic [2:0]        cpu_state_i,
    output logic              halt_o
);
    localparam int CNT_W = $clog2(HALT_CYCLES + 1);
    logic [WORD_W-1:0] prev_pc_q, prev_pc_d;
    logic [CNT_W-1:0]  stuck_q, stuck_d;
    logic              same_fetch;
    assign same_fetch = cpu_state_i == CPU_FETCH && cpu_pc_i == prev_pc_q;
    // All-ones is a word of invalid trits, so a cleared prev_pc never matches a real PC.
    always_comb begin
        stuck_d   = clr_i ? '0 : en_i ? (same_fetch ? stuck_q + 1'b1 : '0) : stuck_q;
        prev_pc_d = clr_i ? '1 : en_i ? cpu_pc_i : prev_pc_q;
    end
    assign halt_o = en_i && stuck_d == CNT_W'(HALT_CYCLES);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_pc_q <= '1;
            stuck_q   <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            stuck_q   <= stuck_d;
        end
    end
endmodule

// File: rtl/system_sequencer.sv
// system_sequencer: load/execute/halt sequencer arbitrating a shared ternary memory port.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i, loader_done_i,
// loader_start_o loader handshake; loader_mem_*_i and cpu_mem_*_i requesters;
// cpu_pc_i/cpu_state_i CPU observation, cpu_enable_o run permission;
// mem_*_o shared memory port; system_state_o, halted_o, timeout_o, bad_trit_o,
// exec_cycles_o status.
module system_sequencer
    import ternary_pkg::*;
#(
    parameter int WORD_W      = 18,
    parameter int HALT_CYCLES = 5,
    parameter int MAX_CYCLES  = 10000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              loader_done_i,
    output logic              loader_start_o,
    input  logic              loader_mem_write_i,
    input  logic [WORD_W-1:0] loader_mem_addr_i,
    input  logic [WORD_W-1:0] loader_mem_wdata_i,
    input  logic              cpu_mem_write_i,
    input  logic [WORD_W-1:0] cpu_mem_addr_i,
    input  logic [WORD_W-1:0] cpu_mem_wdata_i,
    input  logic [WORD_W-1:0] cpu_pc_i,
    input  logic [2:0]        cpu_state_i,
    output logic              cpu_enable_o,
    output logic              mem_write_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic [1:0]        system_state_o,
    output logic              halted_o,
    output logic              timeout_o,
    output logic              bad_trit_o,
    output logic [31:0]       exec_cycles_o
);
    sys_state_e  state_q, state_d;
    logic        loader_start_q, loader_start_d;
    logic        halted_q, halted_d;
    logic        timeout_q, timeout_d;
    logic        bad_trit_q, bad_trit_d;
    logic [31:0] exec_q, exec_d;
    logic        exec, enter_load, halt_det, timeout_det;
    function automatic logic has_bad(input logic [WORD_W-1:0] w);
        for (int i = 0; i < WORD_W / 2; i++)
            if (w[2*i +: 2] == TRIT_BAD) return 1'b1;
        return 1'b0;
    endfunction
    assign exec        = state_q == ST_EXECUTING;
    assign enter_load  = state_q != ST_LOADING && state_d == ST_LOADING;
    assign timeout_det = exec && exec_q + 32'd1 == 32'(MAX_CYCLES);
    halt_detector #(
        .WORD_W     (WORD_W),
        .HALT_CYCLES(HALT_CYCLES)
    ) u_halt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (enter_load),
        .en_i       (exec),
        .cpu_pc_i   (cpu_pc_i),
        .cpu_state_i(cpu_state_i),
        .halt_o     (halt_det)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALTED: state_d = start_i ? ST_LOADING : state_q;
            ST_LOADING:         state_d = loader_done_i ? ST_EXECUTING : state_q;
            default:            state_d = halt_det || timeout_det ? ST_HALTED : state_q;
        endcase
    end
    always_comb begin
        cpu_enable_o   = exec;
        loader_start_o = loader_start_q;
        system_state_o = state_q;
        mem_write_o    = state_q == ST_LOADING ? loader_mem_write_i : exec ? cpu_mem_write_i : 1'b0;
        mem_addr_o     = exec ? cpu_mem_addr_i : loader_mem_addr_i;
        mem_wdata_o    = exec ? cpu_mem_wdata_i : loader_mem_wdata_i;
        halted_o       = halted_q;
        timeout_o      = timeout_q;
        bad_trit_o     = bad_trit_q;
        exec_cycles_o  = exec_q;
    end
    // Halt detection wins over timeout when both fire in the same cycle.
    always_comb begin
        loader_start_d = enter_load;
        exec_d         = enter_load ? '0 : exec ? exec_q + 32'd1 : exec_q;
        halted_d       = enter_load ? 1'b0 : halted_q | (halt_det || timeout_det);
        timeout_d      = enter_load ? 1'b0 : timeout_q | (!halt_det && timeout_det);
        bad_trit_d     = bad_trit_q | (mem_write_o && (has_bad(mem_addr_o) || has_bad(mem_wdata_o)));
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loader_start_q <= 1'b0;
            exec_q         <= '0;
            halted_q       <= 1'b0;
            timeout_q      <= 1'b0;
            bad_trit_q     <= 1'b0;
        end else begin
            loader_start_q <= loader_start_d;
            exec_q         <= exec_d;
            halted_q       <= halted_d;
            timeout_q      <= timeout_d;
            bad_trit_q     <= bad_trit_d;
        end
    end
endmodule
